// File: rtl/keccak_squeezer.sv
// keccak_squeezer
//   Reader end of the f_permutation output interface. Captures the rate part
//   of the permutation state on each new state_valid edge and streams it out
//   as 64-bit digest words over a valid/ready handshake. In XOF mode it pulses
//   squeeze to request more permutations until the requested length is out.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   mode, xof_words       digest selection / XOF length, latched on start
//   start                 arm for one digest (sampled in IDLE only)
//   state_in, state_valid permutation state and its level-valid
//   squeeze               one-cycle request for another permutation
//   dout, dout_valid,
//   dout_ready, dout_last digest word stream
//   busy                  high whenever not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// ARM   | armed, waiting for the first state_valid rise
// EMIT  | streaming words of the captured block
// SQZ   | block exhausted, words remain: squeeze pulse
// WAIT  | waiting for the rise of the next permutation
module keccak_squeezer #(
    parameter int W       = 64,
    parameter int STATE_W = 1600
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic [15:0]        xof_words,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               squeeze,
    output logic [W-1:0]       dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy
);

    localparam int RATE_W = 21 * W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_SQZ  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              sv_q;
    logic [RATE_W-1:0] shreg_q, shreg_d;
    logic [4:0]        blk_q, blk_d;
    logic [15:0]       rem_q, rem_d;

    logic              rise;
    logic              xfer;
    logic [15:0]       start_words;
    logic [4:0]        blk_words;

    // Capacity lanes are never emitted.
    logic              unused_capacity;
    assign unused_capacity = ^state_in[STATE_W-RATE_W-1:0];

    assign rise = state_valid & ~sv_q;
    assign xfer = dout_valid & dout_ready;

    // The digest length is fixed at start; the mode itself need not be kept,
    // since a fixed-length digest always fits in one block.
    always_comb begin
        start_words = 16'd8;
        case (mode)
            2'd0:    start_words = 16'd8;
            2'd1:    start_words = 16'd4;
            2'd2:    start_words = 16'd6;
            default: start_words = (xof_words == 16'd0) ? 16'd1 : xof_words;
        endcase
    end

    assign blk_words = (rem_q > 16'd21) ? 5'd21 : rem_q[4:0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        blk_d   = blk_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    rem_d   = start_words;
                end
            end
            S_ARM, S_WAIT: begin
                if (rise) begin
                    state_d = S_EMIT;
                    shreg_d = state_in[STATE_W-1 -: RATE_W];
                    blk_d   = blk_words;
                end
            end
            S_EMIT: begin
                if (xfer) begin
                    shreg_d = {shreg_q[RATE_W-W-1:0], {W{1'b0}}};
                    blk_d   = blk_q - 5'd1;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1)
                        state_d = S_IDLE;
                    else if (blk_q == 5'd1)
                        state_d = S_SQZ;
                end
            end
            S_SQZ:   state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sv_q    <= 1'b0;
            shreg_q <= '0;
            blk_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sv_q    <= state_valid;
            shreg_q <= shreg_d;
            blk_q   <= blk_d;
            rem_q   <= rem_d;
        end
    end

    assign dout       = shreg_q[RATE_W-1 -: W];
    assign dout_valid = (state_q == S_EMIT);
    assign dout_last  = dout_valid & (rem_q == 16'd1);
    assign squeeze    = (state_q == S_SQZ);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_keccak_squeezer.sv
module tb_keccak_squeezer;

    logic          clk;
    logic          reset_n;
    logic [1:0]    mode;
    logic [15:0]   xof_words;
    logic          start;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          squeeze;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          busy;

    keccak_squeezer dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .xof_words(xof_words),
        .start(start), .state_in(state_in), .state_valid(state_valid),
        .squeeze(squeeze), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // reference model: words still owed for the blocks handed out so far
    logic [63:0]   expq[$];
    int            left;
    logic [1599:0] st;

    typedef struct {
        logic [1:0]  md;
        logic [15:0] xw;
        int          rm;        // 0 always ready, 1 random ready, 2 fixed stall pattern
        int          exp_words;
        int          exp_sq;
    } vec_t;
    vec_t tbl[10];

    task automatic chk_w(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rand_state();
        for (int i = 0; i < 50; i++) st[i*32 +: 32] = $urandom;
    endtask

    // New permutation: lane k of the rate is word k of this block.
    task automatic new_block();
        int n;
        rand_state();
        n = (left > 21) ? 21 : left;
        for (int k = 0; k < n; k++) expq.push_back(st[1599-64*k -: 64]);
        left -= n;
    endtask

    task automatic run_digest(input logic [1:0] md, input logic [15:0] xw, input int rm,
                              output int nwords, output int nsq);
        int          total, cyc, gap, pidx;
        bit          done, stalled, waiting, go, exp_last;
        logic [63:0] held, exp_w;
        logic        held_last;
        logic [10:0] patv;
        patv  = 11'b11111101001;
        total = (md == 2'd0) ? 8 : (md == 2'd1) ? 4 : (md == 2'd2) ? 6 :
                ((xw == 16'd0) ? 1 : int'(xw));
        nwords = 0; nsq = 0; cyc = 0; gap = 0; pidx = 0;
        done = 0; stalled = 0; waiting = 0; held = '0; held_last = 1'b0;
        left = total;
        expq.delete();
        @(negedge clk);
        mode = md; xof_words = xw; start = 1'b1; state_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom);
        xof_words = 16'($urandom);
        new_block();
        state_in = st; state_valid = 1'b1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                chk_b("stall_valid", dout_valid, 1'b1);
                chk_w("stall_dout", dout, held);
                chk_b("stall_last", dout_last, held_last);
            end
            if (waiting) chk_b("wait_valid", dout_valid, 1'b0);
            if (gap > 0) begin
                gap--;
                if (gap == 0) begin
                    new_block();
                    state_in = st; state_valid = 1'b1; waiting = 0;
                end
            end
            if (squeeze) begin
                nsq++;
                chk_b("sqz_valid", dout_valid, 1'b0);
                state_valid = 1'b0;
                gap = $urandom_range(1, 3);
                waiting = 1;
            end
            if (dout_valid) begin
                if (rm == 0) go = 1;
                else if (rm == 1) go = ($urandom_range(0, 2) != 0);
                else begin
                    go = (pidx < 11) ? patv[pidx] : 1'b1;
                    pidx++;
                end
                dout_ready = go;
                if (go) begin
                    stalled = 0;
                    if (expq.size() == 0) begin
                        chk_b("extra_word", 1'b1, 1'b0);
                        done = 1;
                    end else begin
                        exp_w = expq.pop_front();
                        exp_last = (expq.size() == 0) && (left == 0);
                        chk_w("word", dout, exp_w);
                        chk_b("last", dout_last, exp_last);
                        nwords++;
                        if (exp_last) done = 1;
                    end
                end else begin
                    stalled = 1; held = dout; held_last = dout_last;
                end
            end else begin
                stalled = 0;
                dout_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) chk_b("timeout", 1'b0, 1'b1);
        @(negedge clk);
        chk_b("end_valid", dout_valid, 1'b0);
        chk_b("end_busy", busy, 1'b0);
        dout_ready = 1'b0;
    endtask

    initial begin
        int          nw, ns, tot;
        logic [1:0]  rmd;
        logic [15:0] rxw;
        logic [63:0] lv;
        logic [1599:0] st2;

        checks = 0; failures = 0;
        tbl[0] = '{2'd0, 16'd0,  0,  8, 0};
        tbl[1] = '{2'd1, 16'd0,  1,  4, 0};
        tbl[2] = '{2'd2, 16'd99, 1,  6, 0};
        tbl[3] = '{2'd0, 16'd0,  2,  8, 0};
        tbl[4] = '{2'd3, 16'd0,  0,  1, 0};
        tbl[5] = '{2'd3, 16'd21, 1, 21, 0};
        tbl[6] = '{2'd3, 16'd22, 0, 22, 1};
        tbl[7] = '{2'd3, 16'd25, 0, 25, 1};
        tbl[8] = '{2'd3, 16'd42, 1, 42, 1};
        tbl[9] = '{2'd3, 16'd43, 1, 43, 2};

        // reset with random inputs
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = 2'($urandom); xof_words = 16'($urandom); start = 1'($urandom);
            rand_state(); state_in = st; state_valid = 1'($urandom); dout_ready = 1'($urandom);
            @(negedge clk);
            chk_w("rst_dout", dout, 64'd0);
            chk_b("rst_valid", dout_valid, 1'b0);
            chk_b("rst_last", dout_last, 1'b0);
            chk_b("rst_squeeze", squeeze, 1'b0);
            chk_b("rst_busy", busy, 1'b0);
        end
        start = 1'b0; state_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // SHA3-256 with known lanes, no back-pressure
        mode = 2'd1; start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rand_state();
        for (int k = 0; k < 4; k++) begin
            lv = {16{4'(k + 1)}};
            st[1599-64*k -: 64] = lv;
        end
        state_in = st; state_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lv = {16{4'(k + 1)}};
            chk_b("t2_valid", dout_valid, 1'b1);
            chk_w("t2_dout", dout, lv);
            chk_b("t2_last", dout_last, k == 3);
        end
        @(negedge clk);
        chk_b("t2_idle_valid", dout_valid, 1'b0);
        chk_b("t2_idle_busy", busy, 1'b0);

        // start during EMIT ignored; held state_valid never recaptures
        mode = 2'd1; start = 1'b1; state_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; rand_state(); state_in = st; state_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_w("t5_dout", dout, st[1599-64*k -: 64]);
            start = (k == 1);
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_b("t5_valid", dout_valid, 1'b0);
            chk_b("t5_busy", busy, 1'b0);
        end

        // start and rise together: rise ignored, next rise captured
        state_valid = 1'b0;
        @(negedge clk);
        mode = 2'd1; start = 1'b1; rand_state(); state_in = st; state_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_b("t7_busy", busy, 1'b1);
            chk_b("t7_valid", dout_valid, 1'b0);
        end
        state_valid = 1'b0;
        @(negedge clk);
        rand_state(); st2 = st; state_in = st2; state_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_b("t7_wvalid", dout_valid, 1'b1);
            chk_w("t7_dout", dout, st2[1599-64*k -: 64]);
        end
        @(negedge clk);
        chk_b("t7_end_busy", busy, 1'b0);

        // table of digests
        for (int t = 0; t < 10; t++) begin
            run_digest(tbl[t].md, tbl[t].xw, tbl[t].rm, nw, ns);
            chk_i("tbl_words", nw, tbl[t].exp_words);
            chk_i("tbl_squeezes", ns, tbl[t].exp_sq);
        end

        // reset while word 3 is stalled
        state_valid = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rand_state(); state_in = st; state_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        chk_w("t6_word3", dout, st[1599-128 -: 64]);
        @(negedge clk);
        chk_w("t6_stall", dout, st[1599-128 -: 64]);
        reset_n = 1'b0;
        #1;
        chk_w("t6_dout", dout, 64'd0);
        chk_b("t6_valid", dout_valid, 1'b0);
        chk_b("t6_last", dout_last, 1'b0);
        chk_b("t6_busy", busy, 1'b0);
        @(negedge clk);
        state_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            state_valid = ~state_valid;
            @(negedge clk);
            chk_b("t6_post_busy", busy, 1'b0);
            chk_b("t6_post_valid", dout_valid, 1'b0);
        end

        // random digests against the model
        for (int t = 0; t < 12; t++) begin
            rmd = 2'($urandom);
            rxw = 16'($urandom_range(0, 64));
            tot = (rmd == 2'd0) ? 8 : (rmd == 2'd1) ? 4 : (rmd == 2'd2) ? 6 :
                  ((rxw == 16'd0) ? 1 : int'(rxw));
            run_digest(rmd, rxw, 1, nw, ns);
            chk_i("rnd_words", nw, tot);
            chk_i("rnd_squeezes", ns, (tot - 1) / 21);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
